// File: rtl/rvcpu_pkg.sv
// Shared encodings and enums for the multi-cycle RV64I-subset core.
package rvcpu_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {BOOT, FETCH, EXEC, WB, HALT} state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_t;

endpackage

// File: rtl/rvcpu_mc_regfile.sv
// Architectural register file: two combinational reads, one clocked write, x0 hardwired to zero.
module rvcpu_mc_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic [AW-1:0]   a1, a2, aw;

  // In the 16-entry build the top index bit is simply dropped.
  assign a1 = ra1[AW-1:0];
  assign a2 = ra2[AW-1:0];
  assign aw = wa[AW-1:0];

  // NOTE: the whole array is reset because the core must come up with every register reading 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && aw != '0) begin
      regs[aw] <= wd;
    end
  end

  assign rd1 = (a1 == '0) ? '0 : regs[a1];
  assign rd2 = (a2 == '0) ? '0 : regs[a2];

endmodule

// File: rtl/rvcpu_mc.sv
// Multi-cycle RV64I-subset core: BOOT, then FETCH/EXEC/WB per instruction; illegal encodings park in HALT.
module rvcpu_mc
  import rvcpu_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          NREGS    = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            inst_req,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_valid,
  input  logic [31:0]     inst_rdata,
  output logic            commit_valid,
  output logic [XLEN-1:0] commit_pc,
  output logic [4:0]      commit_rd,
  output logic [XLEN-1:0] commit_data,
  output logic            halted
);

  localparam int AW  = $clog2(NREGS);
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, next_pc_q, result_q;
  logic [31:0]     ir_q;

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0] imm_i, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            sh_base_ok, sh_alt_ok;

  logic            illegal, is_jal;
  alu_op_t         alu_op;
  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] exec_result, exec_npc;

  assign opcode  = ir_q[6:0];
  assign rd_idx  = ir_q[11:7];
  assign f3      = ir_q[14:12];
  assign rs1_idx = ir_q[19:15];
  assign rs2_idx = ir_q[24:20];
  assign f7      = ir_q[31:25];

  assign imm_i = XLEN'($signed(ir_q[31:20]));
  assign imm_u = XLEN'($signed({ir_q[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}));

  // RV64 shift immediates borrow funct7 bit 0 as shamt[5].
  assign sh_base_ok = (XLEN == 64) ? (f7[6:1] == F7_BASE[6:1]) : (f7 == F7_BASE);
  assign sh_alt_ok  = (XLEN == 64) ? (f7[6:1] == F7_ALT[6:1])  : (f7 == F7_ALT);

  rvcpu_mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_idx),
    .ra2 (rs2_idx),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (state_q == WB),
    .wa  (rd_idx),
    .wd  (result_q)
  );

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    illegal = 1'b1;
    is_jal  = 1'b0;
    alu_op  = ALU_ADD;
    op_a    = rs1_val;
    op_b    = imm_i;
    case (opcode)
      OP_IMM: begin
        case (f3)
          F3_ADD: illegal = 1'b0;
          F3_XOR: begin alu_op = ALU_XOR; illegal = 1'b0; end
          F3_OR:  begin alu_op = ALU_OR;  illegal = 1'b0; end
          F3_AND: begin alu_op = ALU_AND; illegal = 1'b0; end
          F3_SLL: begin alu_op = ALU_SLL; illegal = !sh_base_ok; end
          F3_SR: begin
            alu_op  = sh_alt_ok ? ALU_SRA : ALU_SRL;
            illegal = !(sh_base_ok || sh_alt_ok);
          end
          default: ;
        endcase
      end
      OP: begin
        op_b = rs2_val;
        if (f7 == F7_BASE) begin
          illegal = 1'b0;
          case (f3)
            F3_ADD:  alu_op = ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: illegal = 1'b1;
          endcase
        end else if (f7 == F7_ALT) begin
          case (f3)
            F3_ADD:  begin alu_op = ALU_SUB; illegal = 1'b0; end
            F3_SR:   begin alu_op = ALU_SRA; illegal = 1'b0; end
            default: ;
          endcase
        end
      end
      LUI:   begin op_a = '0;   op_b = imm_u; illegal = 1'b0; end
      AUIPC: begin op_a = pc_q; op_b = imm_u; illegal = 1'b0; end
      JAL:   begin is_jal = 1'b1; illegal = 1'b0; end
      default: ;
    endcase
  end

  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = op_a + op_b;
    case (alu_op)
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL: alu_res = op_a << shamt;
      ALU_SRL: alu_res = op_a >> shamt;
      ALU_SRA: alu_res = $signed(op_a) >>> shamt;
      default: ;
    endcase
  end

  assign exec_result = is_jal ? (pc_q + XLEN'(4)) : alu_res;
  assign exec_npc    = is_jal ? (pc_q + imm_j)    : (pc_q + XLEN'(4));

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC[XLEN-1:0];
      ir_q      <= '0;
      result_q  <= '0;
      next_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && inst_valid) ir_q <= inst_rdata;
      if (state_q == EXEC) begin
        result_q  <= exec_result;
        next_pc_q <= exec_npc;
      end
      if (state_q == WB) pc_q <= next_pc_q;
    end
  end

  // Commit fields are gated by WB so they read 0 in every other state, including reset.
  always_comb begin
    state_d      = state_q;
    inst_req     = 1'b0;
    commit_valid = 1'b0;
    commit_pc    = '0;
    commit_rd    = '0;
    commit_data  = '0;
    halted       = 1'b0;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        inst_req = 1'b1;
        if (inst_valid) state_d = EXEC;
      end
      EXEC:  state_d = illegal ? HALT : WB;
      WB: begin
        commit_valid = 1'b1;
        commit_pc    = pc_q;
        commit_rd    = rd_idx;
        commit_data  = (ir_q[7 +: AW] != '0) ? result_q : '0;
        state_d      = FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_d = BOOT;
    endcase
  end

  assign inst_addr = pc_q;

endmodule

// File: tb/tb_rvcpu_mc.sv
// Scoreboard bench for rvcpu_mc: directed instruction stream, commits checked by an independent monitor.
module tb_rvcpu_mc;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_valid, commit_valid, halted;
  logic [63:0] inst_addr, commit_pc, commit_data;
  logic [31:0] inst_rdata;
  logic [4:0]  commit_rd;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] data;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, last_cyc = 0;

  rvcpu_mc #(.XLEN(64), .RESET_PC(RPC), .NREGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_valid   (inst_valid),
    .inst_rdata   (inst_rdata),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .halted       (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per commit pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (commit_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: got pc 0x%0h expected no commit", commit_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("commit_pc", commit_pc, e.pc);
          check("commit_rd", 64'(commit_rd), 64'(e.rd));
          check("commit_data", commit_data, e.data);
          if (e.gap > 0) check("commit_gap", 64'(cyc - last_cyc), 64'(e.gap));
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic wait_fetch();
    int n = 0;
    while (inst_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (inst_req !== 1'b1) check("fetch_timeout", 64'(inst_req), 64'(1));
  endtask

  // Called at a negedge; leaves the bench at the next FETCH negedge (or in HALT).
  task automatic run_inst(input logic [31:0] inst, input logic [63:0] pc, input logic [4:0] rd,
                          input logic [63:0] data, input int waits, input bit spurious,
                          input bit legal, input int gap);
    exp_t e;
    wait_fetch();
    check("inst_addr", inst_addr, pc);
    repeat (waits) begin
      @(negedge clk);
      check("stall_req", 64'(inst_req), 64'(1));
    end
    if (legal) begin
      e.pc = pc; e.rd = rd; e.data = data; e.gap = gap;
      exp_q.push_back(e);
    end
    inst_valid = 1'b1;
    inst_rdata = inst;
    @(negedge clk);
    check("req_exec", 64'(inst_req), 64'(0));
    check("halted_exec", 64'(halted), 64'(0));
    inst_valid = spurious;
    inst_rdata = spurious ? 32'hFFFF_FFFF : 32'h0;
    @(negedge clk);
    if (!legal) begin
      check("halted_set", 64'(halted), 64'(1));
      check("req_halt", 64'(inst_req), 64'(0));
      inst_valid = 1'b0;
    end else begin
      inst_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_req", 64'(inst_req), 64'(0));
    check("rst_addr", inst_addr, RPC);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    inst_valid = 1'b0;
    inst_rdata = 32'h0;
    #1;
    check("reset_req", 64'(inst_req), 64'(0));
    check("reset_commit", 64'(commit_valid), 64'(0));
    check("reset_halted", 64'(halted), 64'(0));
    check("reset_addr", inst_addr, RPC);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("boot_req", 64'(inst_req), 64'(0));
    @(negedge clk);
    check("fetch_req", 64'(inst_req), 64'(1));
    check("fetch_addr", inst_addr, RPC);
    repeat (5) begin
      @(negedge clk);
      check("stall_req", 64'(inst_req), 64'(1));
      check("stall_addr", inst_addr, RPC);
    end

    // Zero-wait stream: commits must be exactly 3 cycles apart.
    run_inst(32'h00500093, RPC + 64'h00, 5'd1,  64'd5,                   0, 0, 1, 0);
    run_inst(32'h00108133, RPC + 64'h04, 5'd2,  64'd10,                  0, 0, 1, 3);
    run_inst(32'h401101B3, RPC + 64'h08, 5'd3,  64'd5,                   0, 0, 1, 3);
    run_inst(32'hFFF00093, RPC + 64'h0C, 5'd1,  64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 3);
    run_inst(32'h008002EF, RPC + 64'h10, 5'd5,  64'h8000_0014,           0, 0, 1, 3);
    run_inst(32'h80000237, RPC + 64'h18, 5'd4,  64'hFFFF_FFFF_8000_0000, 0, 0, 1, 3);
    run_inst(32'h0010D093, RPC + 64'h1C, 5'd1,  64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 1, 3);
    run_inst(32'h00700013, RPC + 64'h20, 5'd0,  64'd0,                   0, 0, 1, 3);
    run_inst(32'h00000333, RPC + 64'h24, 5'd6,  64'd0,                   0, 0, 1, 3);
    run_inst(32'h00001397, RPC + 64'h28, 5'd7,  64'h8000_1028,           0, 0, 1, 3);
    run_inst(32'h40425413, RPC + 64'h2C, 5'd8,  64'hFFFF_FFFF_F800_0000, 0, 0, 1, 3);
    run_inst(32'h002194B3, RPC + 64'h30, 5'd9,  64'h1400,                0, 0, 1, 3);
    run_inst(32'hFFF0C513, RPC + 64'h34, 5'd10, 64'h8000_0000_0000_0000, 0, 0, 1, 3);
    run_inst(32'h004575B3, RPC + 64'h38, 5'd11, 64'h8000_0000_0000_0000, 0, 0, 1, 3);
    run_inst(32'h00355633, RPC + 64'h3C, 5'd12, 64'h0400_0000_0000_0000, 0, 0, 1, 3);
    // Wait states plus junk inst_valid during EXEC/WB.
    run_inst(32'h002186B3, RPC + 64'h40, 5'd13, 64'd15,                  2, 1, 1, 0);

    // inst=0 is illegal: core parks in HALT.
    run_inst(32'h00000000, RPC + 64'h44, 5'd0, 64'd0, 0, 0, 0, 0);
    repeat (20) begin
      @(negedge clk);
      check("halt_req", 64'(inst_req), 64'(0));
      check("halt_sticky", 64'(halted), 64'(1));
    end

    // Reset clears halted and the register file (x2 was 10).
    do_reset();
    run_inst(32'h00010793, RPC, 5'd15, 64'd0, 0, 0, 1, 0);
    // funct7 mismatch (MUL encoding) is illegal.
    run_inst(32'h02108133, RPC + 64'h04, 5'd0, 64'd0, 0, 0, 0, 0);
    do_reset();

    // Async reset in the middle of WB swallows the commit.
    wait_fetch();
    inst_valid = 1'b1;
    inst_rdata = 32'h00500093;
    @(negedge clk);
    inst_valid = 1'b0;
    @(posedge clk);
    #2;
    check("wb_commit_before_rst", 64'(commit_valid), 64'(1));
    rst = 1'b1;
    #1;
    check("wb_rst_commit", 64'(commit_valid), 64'(0));
    check("wb_rst_pc", commit_pc, 64'(0));
    check("wb_rst_data", commit_data, 64'(0));
    check("wb_rst_req", 64'(inst_req), 64'(0));
    check("wb_rst_addr", inst_addr, RPC);
    @(negedge clk);
    rst = 1'b0;
    // x1 must not have been written by the interrupted ADDI.
    run_inst(32'h00008793, RPC, 5'd15, 64'd0, 0, 0, 1, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvcpu_mc.md
Name: rvcpu_mc

Overview:
Parametrised multi-cycle successor of the single-cycle rvcpu top. It fetches over a request/valid instruction handshake, executes an RV64I integer subset in a fixed FETCH/EXEC/WB state machine, and reports every retired instruction on a commit port. Illegal encodings halt the core. It sits at the SoC top in place of rvcpu.

Parameters:
XLEN, 64, datapath and register width (32 or 64)
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset (low XLEN bits used)
NREGS, 32, architectural register count (16 for an RV-E style build; rs/rd index MSB ignored when 16)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
inst_req  out  1  fetch request; held high until the beat is accepted
inst_addr  out  XLEN  fetch address (current PC); stable while inst_req=1
inst_valid  in  1  instruction beat valid; sampled only while inst_req=1
inst_rdata  in  32  instruction word
commit_valid  out  1  one-cycle pulse per retired instruction
commit_pc  out  XLEN  PC of the retired instruction
commit_rd  out  5  destination index (0 if none)
commit_data  out  XLEN  value written (0 when rd=x0)
halted  out  1  sticky; set on illegal instruction

Behaviour:
- Reset (async): state=BOOT, pc=RESET_PC, all regs=0, inst_req=0, commit_*=0, halted=0.
- State machine:
  - BOOT: lasts 1 cycle, then FETCH.
  - FETCH: inst_req=1, inst_addr=pc. On a clock edge with inst_valid=1, latch inst_rdata into ir and go to EXEC. inst_req drops in the same cycle.
  - EXEC: decode ir, read rs1/rs2 combinationally from the regfile, compute result and next_pc into registers. Go to WB, or to HALT if illegal.
  - WB: write rd if rd!=0, set pc=next_pc, pulse commit_valid with commit_pc=old pc, then go to FETCH.
  - HALT: absorbing; halted=1, inst_req=0, no commits. Only rst exits.
- Latency: 3 cycles per instruction with zero-wait memory (inst_valid high in the first FETCH cycle). Each extra wait cycle adds 1.
- Supported instructions:
  - OP-IMM: ADDI, XORI, ORI, ANDI, SLLI, SRLI, SRAI. Shift amount is 6 bits when XLEN=64, 5 bits when XLEN=32.
  - OP: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA.
  - LUI, AUIPC, JAL.
- Anything else is illegal, including a funct7 that does not match and inst=0.
- Width rules:
  - Immediates are sign-extended to XLEN.
  - LUI: imm<<12 sign-extended (XLEN=64: 0x80000 gives 0xFFFF_FFFF_8000_0000).
  - Adds and subtracts wrap modulo 2^XLEN.
  - JAL: rd=pc+4, next_pc=pc+imm. Bit 1 of the target is not checked (no misalign trap in this generation).
  - Non-jump next_pc = pc+4, wrapping at 2^XLEN.
- x0 reads as 0; writes to x0 are dropped. commit_rd still reports 0 and commit_data=0.
- inst_valid while inst_req=0 is ignored. It must not advance state or corrupt ir.
- Reset mid-fetch or mid-WB: reset wins immediately. No commit pulse and no register write occur in the reset cycle.

Decomposition:
- Package rvcpu_pkg:
  - opcode constants: OP_IMM, OP, LUI, AUIPC, JAL
  - funct3/funct7 constants
  - state enum: BOOT, FETCH, EXEC, WB, HALT
  - ALU op enum
- Sub-module rvcpu_mc_regfile (NREGS x XLEN): 2 async read ports, 1 sync write port, x0 hardwired, async reset to 0.
- ALU and decode stay inline in rvcpu_mc.

Test Plan:
- Boot: release rst. inst_req must be 0 for 1 cycle, then 1 with inst_addr=0x8000_0000. With inst_valid held low for 5 cycles, inst_req and inst_addr must stay stable.
- Sequence 0x00500093 (ADDI x1,x0,5), 0x00108133 (ADD x2,x1,x1), 0x401101B3 (SUB x3,x2,x1): commits x1=5, x2=10, x3=5 at PCs 0x80000000/04/08, one commit every 3 cycles with zero-wait memory.
- Sign rules:
  - 0xFFF00093 (ADDI x1,x0,-1) gives x1=0xFFFF_FFFF_FFFF_FFFF.
  - 0x80000237 (LUI x4,0x80000) gives x4=0xFFFF_FFFF_8000_0000.
  - 0x0010D093 (SRLI x1,x1,1) gives 0x7FFF_FFFF_FFFF_FFFF.
- JAL: 0x008002EF at pc 0x80000010 gives x5=0x80000014, then next inst_addr=0x80000018. 0x00700013 (ADDI x0,x0,7) commits rd=0, data=0, and x0 still reads 0.
- Illegal 0x00000000: no commit, halted=1 from the cycle after EXEC, inst_req stays 0 for 20 cycles. Asserting rst clears halted and refetches from RESET_PC.
- Async reset asserted during WB: no commit_valid pulse, all outputs at reset values without waiting for a clock edge. Spurious inst_valid pulses during EXEC/WB have no effect.
